boot_loader: RTL and testbench
==============================

# boot_loader

Program loader that sits directly upstream of the multicycle processor's unified data/instruction memory. It holds the processor in reset, receives a byte stream over a valid/ready handshake and assembles 16-bit words. It writes those words into memory through the shared write port, verifies an XOR checksum, and then releases the processor. It owns the memory port only while loading; the top level muxes the port between the loader and the processor using `mem_own`.

## Interface
- `BASE_ADDR`, 16'h0000: memory address of the first loaded word.
- `MAX_WORDS`, 16'd4096: largest legal word count in the header.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `s_data`  in  8  incoming byte.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `mem_adr`  out  16  memory write address.
- `mem_wd`  out  16  memory write data.
- `mem_we`  out  1  one-cycle memory write strobe.
- `mem_own`  out  1  loader drives the memory port; top mux selects the loader when high.
- `cpu_rst`  out  1  active-high reset to the processor.
- `done`  out  1  load completed with a good checksum; sticky.
- `err`  out  1  header or checksum error; sticky.
- `words_loaded`  out  16  number of words written so far.

## Operation
- Stream format, bytes in order:
  - header count N: low byte, then high byte;
  - N words, each low byte then high byte;
  - one checksum byte equal to the XOR of every preceding byte, header included.
- A byte transfers on a rising edge where `s_valid && s_ready`. `s_data` is ignored otherwise.
- States: IDLE, HDR_LO, HDR_HI, DAT_LO, DAT_HI, WRITE, CSUM, DONE, ERR.
- IDLE → HDR_LO unconditionally after one cycle.
- HDR_LO → HDR_HI on transfer.
- HDR_HI on transfer:
  - N > MAX_WORDS → ERR;
  - N == 0 → CSUM;
  - otherwise → DAT_LO.
- DAT_LO → DAT_HI on transfer; DAT_HI → WRITE on transfer.
- WRITE lasts exactly one cycle:
  - `mem_we`=1;
  - `mem_adr`=BASE_ADDR+`words_loaded` (16-bit, wraps modulo 2^16);
  - `mem_wd`={hi,lo};
  - `words_loaded` increments at the end of the cycle;
  - next state CSUM if the incremented count == N, else DAT_LO.
- CSUM on transfer: byte == running XOR → DONE, else ERR.
- DONE and ERR are terminal; only `rst` leaves them.
- `s_ready`=1 in HDR_LO, HDR_HI, DAT_LO, DAT_HI, CSUM; 0 elsewhere.
- `mem_own`=1 in every state except DONE. `cpu_rst`=1 in every state except DONE.
- `mem_we` is asserted only in WRITE. The 16-bit header count compares against MAX_WORDS unsigned.

## Timing
- Reset values: state IDLE, `s_ready`=0, `mem_we`=0, `mem_adr`=0, `mem_wd`=0, `mem_own`=1, `cpu_rst`=1, `done`=0, `err`=0, `words_loaded`=0, running XOR=0.
- All outputs are registered, or decoded from the registered state only. There is no combinational path from `s_valid`/`s_data` to any output.
- Best-case throughput is 3 cycles per word (two byte transfers plus WRITE). Stalls on `s_valid` low are unbounded and lossless.
- `done` and `cpu_rst` change on the same edge: the edge after the checksum transfer.
- `mem_own` falls together with `cpu_rst`, so the processor's first fetch sees the processor-driven port.
- `rst` asserted mid-load aborts immediately. All state returns to reset values, and memory already written is not cleared.
- `s_valid` held high in a non-ready state: no transfer, no side effect.

## Structure
- Shared package holds:
  - the state enum;
  - the 16-bit word width constant;
  - default BASE_ADDR/MAX_WORDS constants, reused by the top-level memory mux.
- One sub-module is natural: `byte_assembler`. It holds the low/high byte registers, the running XOR, and the word-ready pulse.
- The FSM, address counter and outputs stay in `boot_loader`.

## Test plan
1. Stream 02 00 34 12 CD AB 42:
   - writes 16'h1234 @0x0000 and 16'hABCD @0x0001, each `mem_we` 1 cycle;
   - then `done`=1, `cpu_rst`=0, `mem_own`=0, `words_loaded`=2.
2. Stream 00 00 00 (N=0): no `mem_we` pulse; `done`=1 after the third byte.
3. Stream 01 00 11 22 00 (checksum should be 0x32):
   - one write of 16'h2211;
   - then `err`=1, `done`=0, `cpu_rst`=1, `s_ready`=0 permanently.
4. Header 01 10 (N=0x1001 > 4096): `err`=1 on the edge after the second byte; no writes.
5. Case 1 with random `s_valid` gaps of 0–5 cycles: identical write sequence and result; `s_ready` never high in WRITE.
6. Assert `rst` low after the first payload word is written:
   - all outputs return to reset values asynchronously;
   - a fresh case-1 stream then completes with `done`=1.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader and the top-level memory mux.
package boot_loader_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] DEF_BASE_ADDR = 16'h0000;
    localparam logic [WORD_W-1:0] DEF_MAX_WORDS = 16'd4096;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_HDR_LO = 4'd1,
        ST_HDR_HI = 4'd2,
        ST_DAT_LO = 4'd3,
        ST_DAT_HI = 4'd4,
        ST_WRITE  = 4'd5,
        ST_CSUM   = 4'd6,
        ST_DONE   = 4'd7,
        ST_ERR    = 4'd8
    } state_t;

    // One step of the stream checksum: every byte folds in by XOR.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte stream, memory write port and status bundle of the boot loader.
interface boot_loader_if;
    import boot_loader_pkg::*;

    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] mem_adr;
    logic [WORD_W-1:0] mem_wd;
    logic              mem_we;
    logic              mem_own;
    logic              cpu_rst;
    logic              done;
    logic              err;
    logic [WORD_W-1:0] words_loaded;

    // The loader is the slave of the byte stream and drives everything else.
    modport slave (
        input  s_data, s_valid,
        output s_ready, mem_adr, mem_wd, mem_we, mem_own, cpu_rst, done, err, words_loaded
    );

    modport master (
        output s_data, s_valid,
        input  s_ready, mem_adr, mem_wd, mem_we, mem_own, cpu_rst, done, err, words_loaded
    );

endinterface

// File: rtl/boot_loader_byte_assembler.sv
// Collects payload low/high bytes into a word, keeps the running XOR checksum
// and flags the cycle in which a freshly completed word is available.
module byte_assembler
    import boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        i_byte,
    input  logic              i_lo_we,
    input  logic              i_hi_we,
    input  logic              i_acc,
    output logic [WORD_W-1:0] o_word,
    output logic [7:0]        o_xor,
    output logic              o_word_rdy
);

    logic [7:0] r_lo;
    logic [7:0] r_hi;
    logic [7:0] r_xor;
    logic       r_word_rdy;

    // Byte capture, checksum accumulation and word-ready pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo       <= 8'h00;
            r_hi       <= 8'h00;
            r_xor      <= 8'h00;
            r_word_rdy <= 1'b0;
        end else begin
            if (i_lo_we) r_lo <= i_byte;
            if (i_hi_we) r_hi <= i_byte;
            if (i_acc)   r_xor <= csum_step(r_xor, i_byte);
            r_word_rdy <= i_hi_we;
        end
    end

    assign o_word     = {r_hi, r_lo};
    assign o_xor      = r_xor;
    assign o_word_rdy = r_word_rdy;

endmodule

// File: rtl/boot_loader.sv
// Loads a checksummed byte stream into the unified memory while holding the
// processor in reset, then hands the memory port back and releases the CPU.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [WORD_W-1:0] MAX_WORDS = DEF_MAX_WORDS
)(
    input  logic          clk,
    input  logic          rst,
    boot_loader_if.slave  bus
);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_hdr_lo;
    logic [WORD_W-1:0] r_count_n;
    logic [WORD_W-1:0] r_words;
    logic [WORD_W-1:0] r_mem_adr;

    logic              w_s_ready;
    logic              w_mem_we;
    logic              w_mem_own;
    logic              w_cpu_rst;
    logic              w_done;
    logic              w_err;
    logic              w_xfer;
    logic [WORD_W-1:0] w_hdr_n;
    logic              w_lo_we;
    logic              w_hi_we;
    logic              w_acc;
    logic [WORD_W-1:0] w_word;
    logic [7:0]        w_xor;
    logic              w_word_rdy;

    assign w_xfer  = bus.s_valid && w_s_ready;
    assign w_hdr_n = {bus.s_data, r_hdr_lo};
    assign w_lo_we = w_xfer && (r_state == ST_DAT_LO);
    assign w_hi_we = w_xfer && (r_state == ST_DAT_HI);
    assign w_acc   = w_xfer && (r_state != ST_CSUM);

    byte_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst),
        .i_byte     (bus.s_data),
        .i_lo_we    (w_lo_we),
        .i_hi_we    (w_hi_we),
        .i_acc      (w_acc),
        .o_word     (w_word),
        .o_xor      (w_xor),
        .o_word_rdy (w_word_rdy)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   w_next = ST_HDR_LO;
            ST_HDR_LO: if (w_xfer) w_next = ST_HDR_HI; else w_next = r_state;
            ST_HDR_HI: begin
                if (!w_xfer)                    w_next = r_state;
                else if (w_hdr_n > MAX_WORDS)   w_next = ST_ERR;
                else if (w_hdr_n == 16'd0)      w_next = ST_CSUM;
                else                            w_next = ST_DAT_LO;
            end
            ST_DAT_LO: if (w_xfer) w_next = ST_DAT_HI; else w_next = r_state;
            ST_DAT_HI: if (w_xfer) w_next = ST_WRITE;  else w_next = r_state;
            ST_WRITE:  if ((r_words + 16'd1) == r_count_n) w_next = ST_CSUM; else w_next = ST_DAT_LO;
            ST_CSUM: begin
                if (!w_xfer)                 w_next = r_state;
                else if (bus.s_data == w_xor) w_next = ST_DONE;
                else                         w_next = ST_ERR;
            end
            ST_DONE:   w_next = ST_DONE;
            ST_ERR:    w_next = ST_ERR;
            default:   w_next = ST_ERR;
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        w_s_ready = 1'b0;
        w_mem_we  = 1'b0;
        w_mem_own = 1'b1;
        w_cpu_rst = 1'b1;
        w_done    = 1'b0;
        w_err     = 1'b0;
        case (r_state)
            ST_HDR_LO, ST_HDR_HI, ST_DAT_LO, ST_DAT_HI, ST_CSUM: w_s_ready = 1'b1;
            ST_WRITE: w_mem_we = 1'b1;
            ST_DONE: begin
                w_mem_own = 1'b0;
                w_cpu_rst = 1'b0;
                w_done    = 1'b1;
            end
            ST_ERR:  w_err = 1'b1;
            default: w_s_ready = 1'b0;
        endcase
    end

    // Header capture, write address and word counter; address is set up while
    // the high byte lands so it is stable throughout WRITE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hdr_lo  <= 8'h00;
            r_count_n <= 16'd0;
            r_words   <= 16'd0;
            r_mem_adr <= 16'd0;
        end else begin
            if (w_xfer && (r_state == ST_HDR_LO)) r_hdr_lo  <= bus.s_data;
            if (w_xfer && (r_state == ST_HDR_HI)) r_count_n <= w_hdr_n;
            if (w_hi_we)                          r_mem_adr <= BASE_ADDR + r_words;
            if (w_word_rdy)                       r_words   <= r_words + 16'd1;
        end
    end

    assign bus.s_ready      = w_s_ready;
    assign bus.mem_adr      = r_mem_adr;
    assign bus.mem_wd       = w_word;
    assign bus.mem_we       = w_mem_we;
    assign bus.mem_own      = w_mem_own;
    assign bus.cpu_rst      = w_cpu_rst;
    assign bus.done         = w_done;
    assign bus.err          = w_err;
    assign bus.words_loaded = r_words;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: good load, empty load, bad checksum, bad
// header, stalled stream and mid-load reset.
module tb_boot_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    boot_loader_if bus ();

    boot_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errs   = 0;

    logic [15:0] wr_adr [0:15];
    logic [15:0] wr_dat [0:15];
    int          wr_n = 0;
    int          rdy_in_wr = 0;
    logic [7:0]  stream [0:7];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Write monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (wr_n < 16) begin
                wr_adr[wr_n] = bus.mem_adr;
                wr_dat[wr_n] = bus.mem_wd;
            end
            wr_n++;
            if (bus.s_ready === 1'b1) rdy_in_wr++;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, {31'd0, bus.s_ready}, 32'd0);
        chk({tag, "_mem_we"},  {31'd0, bus.mem_we},  32'd0);
        chk({tag, "_mem_adr"}, {16'd0, bus.mem_adr}, 32'd0);
        chk({tag, "_mem_wd"},  {16'd0, bus.mem_wd},  32'd0);
        chk({tag, "_mem_own"}, {31'd0, bus.mem_own}, 32'd1);
        chk({tag, "_cpu_rst"}, {31'd0, bus.cpu_rst}, 32'd1);
        chk({tag, "_done"},    {31'd0, bus.done},    32'd0);
        chk({tag, "_err"},     {31'd0, bus.err},     32'd0);
        chk({tag, "_words"},   {16'd0, bus.words_loaded}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.s_valid = 1'b0;
        wr_n = 0;
        rdy_in_wr = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int cnt;
        @(negedge clk);
        if (gap > 0) begin
            bus.s_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        cnt = 0;
        while (bus.s_ready !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) chk("xfer_timeout", cnt, 32'd0);
        @(posedge clk);
    endtask

    task automatic send_stream(input int n, input int maxgap);
        for (int i = 0; i < n; i++)
            send_byte(stream[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic load_case1();
        stream[0] = 8'h02; stream[1] = 8'h00; stream[2] = 8'h34; stream[3] = 8'h12;
        stream[4] = 8'hCD; stream[5] = 8'hAB; stream[6] = 8'h42;
    endtask

    task automatic chk_case1(input string tag);
        chk({tag, "_nwr"},   wr_n, 32'd2);
        chk({tag, "_adr0"},  {16'd0, wr_adr[0]}, 32'h0000);
        chk({tag, "_dat0"},  {16'd0, wr_dat[0]}, 32'h1234);
        chk({tag, "_adr1"},  {16'd0, wr_adr[1]}, 32'h0001);
        chk({tag, "_dat1"},  {16'd0, wr_dat[1]}, 32'hABCD);
        chk({tag, "_done"},  {31'd0, bus.done},    32'd1);
        chk({tag, "_err"},   {31'd0, bus.err},     32'd0);
        chk({tag, "_cpurst"},{31'd0, bus.cpu_rst}, 32'd0);
        chk({tag, "_own"},   {31'd0, bus.mem_own}, 32'd0);
        chk({tag, "_words"}, {16'd0, bus.words_loaded}, 32'd2);
        chk({tag, "_rdy"},   {31'd0, bus.s_ready}, 32'd0);
    endtask

    initial begin
        int cnt;
        rst = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        #22;
        chk_reset_outputs("rst0");
        @(negedge clk);
        rst = 1'b1;

        // Case 1: two-word load, checksum checked before and after the last byte
        load_case1();
        send_stream(6, 0);
        chk("c1_done_early",  {31'd0, bus.done},    32'd0);
        chk("c1_cpurst_early",{31'd0, bus.cpu_rst}, 32'd1);
        send_byte(8'h42, 0);
        @(negedge clk);
        bus.s_valid = 1'b0;
        chk_case1("c1");

        // Case 2: empty image
        do_reset();
        stream[0] = 8'h00; stream[1] = 8'h00; stream[2] = 8'h00;
        send_stream(3, 0);
        chk("c2_nwr",  wr_n, 32'd0);
        chk("c2_done", {31'd0, bus.done}, 32'd1);
        chk("c2_words",{16'd0, bus.words_loaded}, 32'd0);

        // Case 3: bad checksum (expected 0x32)
        do_reset();
        stream[0] = 8'h01; stream[1] = 8'h00; stream[2] = 8'h11; stream[3] = 8'h22; stream[4] = 8'h00;
        send_stream(5, 0);
        repeat (5) @(negedge clk);
        chk("c3_nwr",    wr_n, 32'd1);
        chk("c3_adr0",   {16'd0, wr_adr[0]}, 32'h0000);
        chk("c3_dat0",   {16'd0, wr_dat[0]}, 32'h2211);
        chk("c3_err",    {31'd0, bus.err},     32'd1);
        chk("c3_done",   {31'd0, bus.done},    32'd0);
        chk("c3_cpurst", {31'd0, bus.cpu_rst}, 32'd1);
        chk("c3_rdy",    {31'd0, bus.s_ready}, 32'd0);

        // Case 4: oversized header, then valid held high in the error state
        do_reset();
        stream[0] = 8'h01; stream[1] = 8'h10;
        send_byte(stream[0], 0);
        send_byte(stream[1], 0);
        @(negedge clk);
        chk("c4_err", {31'd0, bus.err}, 32'd1);
        bus.s_data = 8'h55;
        repeat (5) @(negedge clk);
        bus.s_valid = 1'b0;
        chk("c4_nwr",   wr_n, 32'd0);
        chk("c4_words", {16'd0, bus.words_loaded}, 32'd0);
        chk("c4_rdy",   {31'd0, bus.s_ready}, 32'd0);
        chk("c4_err_hold", {31'd0, bus.err}, 32'd1);

        // Case 5: case 1 with random stalls
        do_reset();
        load_case1();
        send_stream(7, 5);
        chk_case1("c5");
        chk("c5_rdy_in_write", rdy_in_wr, 32'd0);

        // Case 6: reset after the first word is written, then a fresh load
        do_reset();
        load_case1();
        send_stream(4, 0);
        cnt = 0;
        while (wr_n < 1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("c6_first_write", wr_n, 32'd1);
        chk("c6_words_mid", {16'd0, bus.words_loaded}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("c6rst");
        wr_n = 0;
        rdy_in_wr = 0;
        @(negedge clk);
        rst = 1'b1;
        send_stream(7, 0);
        chk_case1("c6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
